// File: rtl/cdc_pkg.sv
// Shared types and constants for the req/ack clock-domain-crossing blocks.
package cdc_pkg;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_REQ      = 2'd1,
        HS_WAIT_LOW = 2'd2
    } hs_src_state_e;

    localparam int HS_MIN_SYNC_LENGTH = 2;

endpackage

// File: rtl/cdc_handshake_src_if.sv
// Upstream valid/ready port plus the req/ack/data lines toward the destination domain.
interface cdc_handshake_src_if #(
    parameter int WIDTH = 8
);
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             ready_o;
    logic             req_o;
    logic [WIDTH-1:0] data_o;
    logic             ack_i;
    logic             done_o;

    // master: the handshake source block; slave: its environment (upstream + destination).
    modport master (
        input  valid_i, data_i, ack_i,
        output ready_o, req_o, data_o, done_o
    );

    modport slave (
        output valid_i, data_i, ack_i,
        input  ready_o, req_o, data_o, done_o
    );

endinterface

// File: rtl/chain_synchronizer.sv
// Multi-flop level synchronizer; output is the input delayed LENGTH clk edges.
module chain_synchronizer #(
    parameter int LENGTH = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic data_i,
    output logic data_o
);

    logic [LENGTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[LENGTH-2:0], data_i};
        end
    end

    assign data_o = sync_q[LENGTH-1];

endmodule

// File: rtl/cdc_handshake_src.sv
// Source half of a four-phase req/ack multi-bit CDC: holds a word on data_o while req_o is up.
module cdc_handshake_src
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_LENGTH = 3
) (
    input  logic                clk_src,
    input  logic                reset_master_src_n,
    cdc_handshake_src_if.master bus,
    output hs_src_state_e       state_o
);

    generate
        if (SYNC_LENGTH < HS_MIN_SYNC_LENGTH) begin : g_bad_sync_length
            $error("cdc_handshake_src: SYNC_LENGTH below HS_MIN_SYNC_LENGTH");
        end
    endgenerate

    hs_src_state_e    state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             ack_s;
    logic             ready;

    chain_synchronizer #(
        .LENGTH (SYNC_LENGTH)
    ) u_ack_sync (
        .clk     (clk_src),
        .reset_n (reset_master_src_n),
        .data_i  (bus.ack_i),
        .data_o  (ack_s)
    );

    // Handshake: a word transfers on a clk_src edge where valid_i && ready_o; ready_o does not
    // depend on valid_i, and upstream holds valid_i/data_i stable until that edge.
    // A still-high ack (stale, e.g. after a source-only reset) blocks acceptance.
    assign ready = (state_q == HS_IDLE) && !ack_s;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (bus.valid_i && ready) begin
                    data_d  = bus.data_i;
                    req_d   = 1'b1;
                    state_d = HS_REQ;
                end
            end
            HS_REQ: begin
                req_d = 1'b1;
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = HS_WAIT_LOW;
                end
            end
            HS_WAIT_LOW: begin
                req_d = 1'b0;
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = HS_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = HS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_src or negedge reset_master_src_n) begin
        if (!reset_master_src_n) begin
            state_q <= HS_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready_o = ready;
    assign bus.req_o   = req_q;
    assign bus.data_o  = data_q;
    assign bus.done_o  = done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Directed bench for cdc_handshake_src: reset, single transfer, busy ignore, stale ack, reset abort, stream.
module tb_cdc_handshake_src;
    import cdc_pkg::*;

    localparam int WIDTH       = 8;
    localparam int SYNC_LENGTH = 3;

    logic          clk_src = 1'b0;
    logic          clk_dest = 1'b0;
    logic          reset_master_src_n;
    hs_src_state_e state_o;

    cdc_handshake_src_if #(.WIDTH(WIDTH)) bus ();

    cdc_handshake_src #(
        .WIDTH       (WIDTH),
        .SYNC_LENGTH (SYNC_LENGTH)
    ) dut (
        .clk_src            (clk_src),
        .reset_master_src_n (reset_master_src_n),
        .bus                (bus),
        .state_o            (state_o)
    );

    // ---------------- clock / reset ----------------
    always #15 clk_src = ~clk_src;
    always #5 clk_dest = ~clk_dest;

    // ---------------- destination responder ----------------
    logic             e2e_mode = 1'b0;
    logic             ack_man = 1'b0;
    logic [2:0]       dreq = 3'b000;
    logic [WIDTH-1:0] recv_q[$];
    logic [WIDTH-1:0] exp_q[$];

    assign bus.ack_i = e2e_mode ? dreq[2] : ack_man;

    always @(posedge clk_dest) begin
        dreq <= {dreq[1:0], bus.req_o};
        if (e2e_mode && dreq[1] && !dreq[2]) recv_q.push_back(bus.data_o);
    end

    // ---------------- source-side monitors ----------------
    int               done_cnt = 0;
    int               viol_cnt = 0;
    logic             prev_req = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    always @(negedge clk_src) begin
        if (e2e_mode) begin
            if (bus.done_o) done_cnt <= done_cnt + 1;
            if (bus.req_o && prev_req && bus.data_o != prev_data) viol_cnt <= viol_cnt + 1;
        end
        prev_req  <= bus.req_o;
        prev_data <= bus.data_o;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_src);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d);
        logic accepted;
        accepted = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        for (int i = 0; i < 100 && !accepted; i++) begin
            if (bus.ready_o) accepted = 1'b1;
            tick();
        end
        bus.valid_i = 1'b0;
        check("send_accept", {31'd0, accepted}, 32'd1);
        exp_q.push_back(d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_master_src_n = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        repeat (3) tick();

        check("rst_req",   {31'd0, bus.req_o},   32'd0);
        check("rst_data",  {24'd0, bus.data_o},  32'h00);
        check("rst_done",  {31'd0, bus.done_o},  32'd0);
        check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        check("rst_state", {30'd0, state_o},     {30'd0, HS_IDLE});

        // single transfer with busy-ignore
        reset_master_src_n = 1'b1;
        tick();
        bus.valid_i = 1'b1;
        bus.data_i  = 8'hA5;
        tick();
        check("acc_req",   {31'd0, bus.req_o},   32'd1);
        check("acc_data",  {24'd0, bus.data_o},  32'hA5);
        check("acc_ready", {31'd0, bus.ready_o}, 32'd0);
        bus.data_i = 8'h3C;
        repeat (3) tick();
        check("busy_data", {24'd0, bus.data_o}, 32'hA5);
        check("busy_req",  {31'd0, bus.req_o},  32'd1);
        ack_man = 1'b1;
        repeat (3) tick();
        check("ack_sync_req_hold", {31'd0, bus.req_o}, 32'd1);
        tick();
        check("ack_req_fall",  {31'd0, bus.req_o},  32'd0);
        check("wait_state",    {30'd0, state_o},    {30'd0, HS_WAIT_LOW});
        check("wait_data",     {24'd0, bus.data_o}, 32'hA5);
        check("wait_done",     {31'd0, bus.done_o}, 32'd0);
        check("wait_ready",    {31'd0, bus.ready_o}, 32'd0);
        ack_man = 1'b0;
        bus.valid_i = 1'b0;
        repeat (3) tick();
        check("ackl_done_early", {31'd0, bus.done_o},  32'd0);
        check("ackl_ready_early", {31'd0, bus.ready_o}, 32'd0);
        tick();
        check("done_pulse", {31'd0, bus.done_o},  32'd1);
        check("done_ready", {31'd0, bus.ready_o}, 32'd1);
        check("done_data",  {24'd0, bus.data_o},  32'hA5);
        tick();
        check("done_one_cycle", {31'd0, bus.done_o}, 32'd0);
        check("no_second_req",  {31'd0, bus.req_o},  32'd0);

        // stale ack after source-only reset
        reset_master_src_n = 1'b0;
        ack_man = 1'b1;
        repeat (2) tick();
        reset_master_src_n = 1'b1;
        repeat (3) tick();
        check("stale_ready", {31'd0, bus.ready_o}, 32'd0);
        bus.valid_i = 1'b1;
        bus.data_i  = 8'h77;
        repeat (2) tick();
        check("stale_no_req",  {31'd0, bus.req_o},  32'd0);
        check("stale_no_data", {24'd0, bus.data_o}, 32'h00);
        ack_man = 1'b0;
        repeat (2) tick();
        check("stale_ready_hold", {31'd0, bus.ready_o}, 32'd0);
        tick();
        check("stale_ready_rise", {31'd0, bus.ready_o}, 32'd1);
        check("stale_req_low",    {31'd0, bus.req_o},   32'd0);
        tick();
        check("post_stale_req",  {31'd0, bus.req_o},  32'd1);
        check("post_stale_data", {24'd0, bus.data_o}, 32'h77);
        bus.valid_i = 1'b0;

        // reset while req_o is high
        reset_master_src_n = 1'b0;
        #1;
        check("abort_req",   {31'd0, bus.req_o},  32'd0);
        check("abort_data",  {24'd0, bus.data_o}, 32'h00);
        check("abort_done",  {31'd0, bus.done_o}, 32'd0);
        check("abort_state", {30'd0, state_o},    {30'd0, HS_IDLE});
        tick();
        reset_master_src_n = 1'b1;
        tick();
        bus.valid_i = 1'b1;
        bus.data_i  = 8'h5A;
        tick();
        bus.valid_i = 1'b0;
        check("resume_req",  {31'd0, bus.req_o},  32'd1);
        check("resume_data", {24'd0, bus.data_o}, 32'h5A);
        ack_man = 1'b1;
        repeat (4) tick();
        check("resume_req_fall", {31'd0, bus.req_o}, 32'd0);
        ack_man = 1'b0;
        repeat (3) tick();
        check("resume_done_early", {31'd0, bus.done_o}, 32'd0);
        tick();
        check("resume_done", {31'd0, bus.done_o},  32'd1);
        check("resume_hold", {24'd0, bus.data_o}, 32'h5A);
        tick();

        // end-to-end stream through the destination responder
        e2e_mode = 1'b1;
        for (int w = 1; w <= 4; w++) send_word(WIDTH'(w));
        for (int i = 0; i < 300 && done_cnt < 4; i++) tick();
        repeat (4) tick();
        check("stream_done_pulses", done_cnt, 32'd4);
        check("stream_data_stable", viol_cnt, 32'd0);
        check("stream_recv_count",  recv_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] obs;
            obs = (i < recv_q.size()) ? {24'd0, recv_q[i]} : 32'hFFFF_FFFF;
            check($sformatf("stream_word%0d", i), obs, {24'd0, exp_q[i]});
        end
        e2e_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_src.md
# cdc_handshake_src

Source-domain half of a four-phase req/ack multi-bit clock-domain crossing. It accepts a WIDTH-bit word on a valid/ready interface in the clk_src domain and holds it stable on data_o. It raises a level req_o, which the destination domain passes through a chain_synchronizer, then waits for the destination's ack_i to complete the four-phase cycle. It feeds the destination-side chain_synchronizer directly and resynchronizes the returning ack internally.

## Interface
- WIDTH, 8, bits per transferred word
- SYNC_LENGTH, 3, flops in the internal ack synchronizer; legal range ≥ 2
- clk_src  input  1  source clock
- reset_master_src_n  input  1  reset, asynchronous, active-low (already-synchronized master reset for clk_src)
- valid_i  input  1  upstream has a word
- data_i  input  WIDTH  upstream word
- ready_o  output  1  block can accept a word this cycle
- req_o  output  1  registered four-phase request to the destination (drives the dest chain_synchronizer data_i)
- data_o  output  WIDTH  registered held word; crosses unsynchronized; stable for the whole time req_o is high
- ack_i  input  1  asynchronous acknowledge from the destination domain
- done_o  output  1  one-cycle pulse when a transfer's four-phase cycle completes

## Operation
- ack_i passes through an internal chain_synchronizer (SYNC_LENGTH, clk_src, reset_master_src_n) to produce ack_s. No other logic samples ack_i.
- FSM states:
  - HS_IDLE
    - ready_o = ~ack_s.
    - On valid_i & ready_o: capture data_i into data_o, set req_o = 1, go to HS_REQ.
  - HS_REQ
    - req_o held at 1, data_o held.
    - On ack_s = 1: clear req_o, go to HS_WAIT_LOW.
  - HS_WAIT_LOW
    - req_o = 0, data_o held.
    - On ack_s = 0: pulse done_o, go to HS_IDLE.
- ready_o is 0 in HS_REQ and HS_WAIT_LOW.
- valid_i/data_i are ignored whenever ready_o = 0. Upstream must hold valid_i until it sees the handshake.
- Stale ack: if ack_s = 1 in HS_IDLE (e.g. after a source-only reset), ready_o stays 0 until ack_s falls. A new req is never raised against a high ack.
- data_o changes only on an accepting edge. It never changes while req_o = 1 or while in HS_WAIT_LOW.
- Reset (asynchronous, any state):
  - state = HS_IDLE
  - req_o = 0
  - data_o = '0
  - done_o = 0
  - ack synchronizer flops = 0
  - ready_o is 1 during reset.
  - A transfer in flight at reset is abandoned, not retried. The destination observes req fall and drops ack normally.

## Timing
- All outputs are registered except ready_o, which is combinational from state and ack_s.
- Accept at edge N: req_o = 1 and data_o valid after edge N; ready_o = 0 after edge N.
- ack_i rising before edge K: ack_s = 1 after edge K+SYNC_LENGTH-1; req_o falls after edge K+SYNC_LENGTH.
- ack_i falling follows the same latency for ack_s. done_o is high for exactly the one cycle following the edge that samples ack_s = 0 in HS_WAIT_LOW. ready_o rises in that same cycle.
- Minimum source-cycle cost per word: 1 + 2·(SYNC_LENGTH+1) plus the destination-side round trip.
- Throughput is one word per full four-phase cycle; there is no pipelining of requests.

## Structure
- Package cdc_pkg holds:
  - typedef enum logic [1:0] hs_src_state_e {HS_IDLE, HS_REQ, HS_WAIT_LOW}
  - localparam HS_MIN_SYNC_LENGTH = 2
- One sub-module: chain_synchronizer (existing) for ack_i → ack_s.
- Elaboration-time check fails if SYNC_LENGTH < HS_MIN_SYNC_LENGTH.

## Test plan
- Bench clocks: clk_src period 30 ns, clk_dest period 10 ns. SYNC_LENGTH = 3 unless noted.
- Reset: hold reset_master_src_n = 0 with ack_i = 0 → req_o = 0, data_o = 8'h00, done_o = 0, ready_o = 1.
- Single transfer: valid_i = 1, data_i = 8'hA5 at edge N → req_o = 1, data_o = A5 after N. Drive ack_i = 1 before edge K → req_o = 0 after K+3. Drive ack_i = 0 → one done_o pulse, ready_o = 1, data_o still A5.
- Busy ignore: during HS_REQ drive valid_i = 1, data_i = 8'h3C → data_o stays A5; no second req until done_o.
- Stale ack: release reset with ack_i = 1 → ready_o = 0 and no accept despite valid_i = 1. Drop ack_i → ready_o = 1 three edges later.
- Reset mid-transfer: assert reset while req_o = 1 → req_o, data_o = 0 immediately, with no done_o pulse. After reset, the next word 8'h5A completes normally once ack_i has fallen.
- End-to-end stream: attach a dest-side responder (chain_synchronizer on req_o, ack = synchronized req, capture data_o on synchronized req rise). Send 8'h01–8'h04 back-to-back → received in order, exactly 4 done_o pulses, data_o never changes while req_o = 1.
